adder_measure_sequencer: RTL and testbench

- Host-side initiator for the instrumented adder wrappers (kogge, ripple, etc.).
- Sits between a command source (management core via logic analyser, or a Wishbone shim) and the adder's control/observe bus.
- For each command it loads the A/B operands, clears the ring counter, enables the ring oscillator, opens a counting window of programmable length, then closes it. After a short drain it captures the count and sum and returns a result record with a sum-correctness flag.

---
 rtl/adder_measure_sequencer.sv | 102 ++++++++++
 tb/tb_adder_measure_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer: drives one ring-oscillator timing measurement per command and returns count, sum and correctness
module adder_measure_sequencer #(
  parameter int WIDTH = 32,
  parameter int WIN_W = 16,
  parameter int SETTLE = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIN_W-1:0] cmd_window,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_count,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_ok,
  output logic             busy,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_ring_en,
  output logic             dut_count_en,
  output logic             dut_count_clear,
  input  logic [WIDTH-1:0] dut_count,
  input  logic [WIDTH-1:0] dut_sum
);
  localparam int CW = WIN_W > 8 ? WIN_W : 8;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETTLE, S_COUNT, S_DRAIN, S_CAPTURE, S_RESULT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIN_W-1:0] win_q;
  // next state and phase down-counter; each timed phase loads its length minus one on entry
  always_comb begin
    nxt = state;
    cnt_nxt = cnt - CW'(1);
    unique case (state)
      S_IDLE: nxt = (cmd_valid && cmd_ready) ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        nxt = S_SETTLE;
        cnt_nxt = CW'(SETTLE - 1);
      end
      S_SETTLE: if (cnt == '0) begin
        nxt = (win_q == '0) ? S_DRAIN : S_COUNT;
        cnt_nxt = (win_q == '0) ? CW'(1) : CW'(win_q) - CW'(1);
      end
      S_COUNT: if (cnt == '0) begin
        nxt = S_DRAIN;
        cnt_nxt = CW'(1);
      end
      S_DRAIN: nxt = (cnt == '0) ? S_CAPTURE : S_DRAIN;
      S_CAPTURE: nxt = S_RESULT;
      S_RESULT: nxt = res_ready ? S_IDLE : S_RESULT;
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end
  // state, latched command and registered outputs, all decoded from the next state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      win_q <= '0;
      cmd_ready <= 1'b0;
      busy <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_sum <= '0;
      res_ok <= 1'b0;
      dut_a <= '0;
      dut_b <= '0;
      dut_ring_en <= 1'b0;
      dut_count_en <= 1'b0;
      dut_count_clear <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (nxt == S_CLEAR) begin
        a_q <= cmd_a;
        b_q <= cmd_b;
        win_q <= cmd_window;
        dut_a <= cmd_a;
        dut_b <= cmd_b;
      end
      if (state == S_CAPTURE && nxt == S_RESULT) begin
        res_count <= dut_count;
        res_sum <= dut_sum;
        res_ok <= dut_sum == WIDTH'(a_q + b_q);
      end
      cmd_ready <= nxt == S_IDLE;
      busy <= nxt != S_IDLE;
      res_valid <= nxt == S_RESULT;
      dut_ring_en <= nxt == S_SETTLE || nxt == S_COUNT;
      dut_count_en <= nxt == S_COUNT;
      dut_count_clear <= nxt == S_CLEAR;
    end
  end
endmodule

// File: tb/tb_adder_measure_sequencer.sv
// tb_adder_measure_sequencer: scoreboard bench with an adder/ring-counter model behind the sequencer
module tb_adder_measure_sequencer;
  localparam int ST = 4;
  logic wb_clk_i = 0, wb_rst_i = 1, abort = 0, cmd_valid = 0, res_ready;
  logic cmd_ready, res_valid, res_ok, busy, dut_ring_en, dut_count_en, dut_count_clear;
  logic [31:0] cmd_a = 0, cmd_b = 0, res_count, res_sum, dut_a, dut_b, dut_count, dut_sum;
  logic [15:0] cmd_window = 0;
  logic [31:0] mcnt = 0, force_val = 0;
  logic force_en = 0, rr_rnd = 1;
  logic [1:0] rr_mode = 2;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct { int t; int t_res; int win; logic [31:0] a, b, sum, count; logic ok; } exp_t;
  exp_t q[$];

  adder_measure_sequencer #(.WIDTH(32), .WIN_W(16), .SETTLE(ST)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .abort(abort), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_window(cmd_window),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count), .res_sum(res_sum),
    .res_ok(res_ok), .busy(busy), .dut_a(dut_a), .dut_b(dut_b), .dut_ring_en(dut_ring_en),
    .dut_count_en(dut_count_en), .dut_count_clear(dut_count_clear), .dut_count(dut_count),
    .dut_sum(dut_sum));

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // instrumented adder model: ring counter advances by two per enabled cycle
  always @(posedge wb_clk_i) mcnt <= dut_count_clear ? 32'd0 : dut_count_en ? mcnt + 32'd2 : mcnt;
  assign dut_count = mcnt;
  assign dut_sum = force_en ? force_val : dut_a + dut_b;

  always @(posedge wb_clk_i) begin #1; rr_rnd = $urandom_range(0, 2) != 0; end
  assign res_ready = rr_mode == 2'd0 ? rr_rnd : rr_mode == 2'd2;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) begin @(posedge wb_clk_i); #1; end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input int win, input logic cor, input logic [31:0] fv, output int t);
    exp_t e;
    int n = 0;
    @(posedge wb_clk_i); #1;
    while (q.size() != 0 && n < 2000) begin @(posedge wb_clk_i); #1; n++; end
    force_en = cor;
    force_val = fv;
    cmd_a = a; cmd_b = b; cmd_window = 16'(win); cmd_valid = 1;
    t = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge wb_clk_i);
      if (cmd_ready && !abort) begin t = cyc; break; end
      @(posedge wb_clk_i); #1;
    end
    check("accept_timeout", t < 0, 0);
    if (t >= 0) begin
      e.t = t; e.t_res = t + ST + win + 5; e.win = win; e.a = a; e.b = b;
      e.sum = cor ? fv : a + b;
      e.ok = e.sum == a + b;
      e.count = 32'(2 * win);
      q.push_back(e);
    end
    @(posedge wb_clk_i); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin @(negedge wb_clk_i); n++; end
    check("done_timeout", q.size(), 0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ctl"}, {cmd_ready, res_valid, res_ok, busy, dut_ring_en, dut_count_en, dut_count_clear}, 0);
    check({nm, "_res"}, {res_count, res_sum}, 0);
    check({nm, "_dut"}, {dut_a, dut_b}, 0);
  endtask

  logic prev_rv = 0, prev_hs = 0, prev_ce = 0;
  logic [64:0] held = 0;
  // monitor: timing of the control strobes and result records against the scoreboard head
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (res_valid && (!prev_rv || prev_hs)) begin
        check("unexpected_result", q.size() != 0, 1);
        if (q.size() != 0) check("res_latency", cyc, q[0].t_res);
      end else if (res_valid) check("res_stable", {res_count, res_sum, res_ok}, held);
      if (res_valid) check("cmd_ready_in_result", cmd_ready, 0);
      if (res_valid && res_ready && q.size() != 0) begin
        check("res_count", res_count, q[0].count);
        check("res_sum", res_sum, q[0].sum);
        check("res_ok", res_ok, q[0].ok);
        void'(q.pop_front());
      end
      if (dut_count_clear) begin
        check("clear_no_cmd", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("clear_time", cyc, q[0].t + 1);
          check("dut_operands", {dut_a, dut_b}, {q[0].a, q[0].b});
        end
      end
      if (dut_count_en && !prev_ce) begin
        check("count_en_no_cmd", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("count_en_zero_win", q[0].win != 0, 1);
          check("count_en_start", cyc, q[0].t + ST + 2);
        end
      end
      if (dut_count_en) check("count_en_ring", dut_ring_en, 1);
    end
    prev_rv = res_valid;
    prev_hs = res_valid && res_ready;
    prev_ce = dut_count_en;
    held = {res_count, res_sum, res_ok};
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int t, t2, r;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check_zero("reset");
    @(posedge wb_clk_i); #1;
    wb_rst_i = 0;
    repeat (2) @(negedge wb_clk_i);
    check("idle_ready", {cmd_ready, busy}, 2'b10);
    send(32'd3, 32'd5, 10, 0, 0, t);
    wait_done();
    send(32'hFFFF_FFFF, 32'd1, 5, 0, 0, t);
    wait_done();
    send(32'hFFFF_FFFF, 32'd1, 5, 1, 32'h0002_0000, t);
    wait_done();
    send(32'd7, 32'd9, 0, 0, 0, t);
    wait_done();
    // abort while idle must block acceptance
    @(posedge wb_clk_i); #1;
    cmd_valid = 1; abort = 1;
    @(posedge wb_clk_i); #1;
    cmd_valid = 0; abort = 0;
    @(negedge wb_clk_i);
    check("abort_idle_busy", {busy, dut_count_clear}, 0);
    // backpressure: result held for 7 cycles while a second command waits
    rr_mode = 1;
    send(32'd100, 32'd23, 3, 0, 0, t);
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge wb_clk_i);
    check("bp_res_valid", res_valid, 1);
    cmd_a = 32'd1; cmd_b = 32'd2; cmd_window = 16'd2;
    for (int i = 0; i < 7; i++) begin
      @(posedge wb_clk_i); #1;
      cmd_valid = 1;
      @(negedge wb_clk_i);
      check("bp_cmd_ready", {cmd_ready, busy, res_valid}, 3'b011);
    end
    @(posedge wb_clk_i); #1;
    rr_mode = 2;
    @(negedge wb_clk_i);
    r = cyc;
    check("bp_release_ready", cmd_ready, 0);
    send(32'd1, 32'd2, 2, 0, 0, t2);
    check("bp_second_accept", t2, r + 1);
    wait_done();
    // abort during COUNT
    send(32'd11, 32'd22, 10, 0, 0, t);
    to_cycle(t + 8);
    abort = 1;
    @(posedge wb_clk_i); #1;
    abort = 0;
    @(negedge wb_clk_i);
    check("abort_state", {dut_ring_en, dut_count_en, busy, cmd_ready, res_valid}, 5'b00010);
    q.delete();
    repeat (30) @(negedge wb_clk_i);
    send(32'd40, 32'd2, 4, 0, 0, t);
    wait_done();
    // reset during SETTLE
    send(32'd3, 32'd5, 10, 0, 0, t);
    to_cycle(t + 3);
    wb_rst_i = 1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 0;
    @(negedge wb_clk_i);
    check_zero("reset_mid");
    q.delete();
    send(32'd3, 32'd5, 10, 0, 0, t);
    wait_done();
    // randomized traffic with random backpressure and random corruption
    rr_mode = 0;
    for (int i = 0; i < 25; i++) begin
      send($urandom, $urandom, $urandom_range(0, 12), $urandom_range(0, 3) == 0, $urandom, t);
    end
    wait_done();
    repeat (3) @(negedge wb_clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
